// File: rtl/xor_ref_model_pkg.sv
// Shared definitions for the XOR-encrypt reference model and the DUT bench.
package xor_pkg;

  localparam int DW      = 256;
  localparam int LAT_MIN = 1;
  localparam int LAT_MAX = 16;

  typedef logic [DW-1:0] code_t;

  // Reduce a rotate amount into 0..dw-1 (negative amounts wrap as well).
  function automatic int rot_mod(input int rot, input int dw);
    if (dw <= 0) begin
      return 0;
    end
    return ((rot % dw) + dw) % dw;
  endfunction

  // Left-rotate a code word by n bits, n taken modulo DW.
  function automatic code_t rotl(input code_t x, input int n);
    int m;
    m = rot_mod(n, DW);
    if (m == 0) begin
      return x;
    end
    return (x << m) | (x >> (DW - m));
  endfunction

endpackage

// File: rtl/xor_delay_line.sv
// Valid+data shift register. A stage holding no block always holds zero data,
// so the tail data is zero whenever the tail valid is low.
module xor_delay_line #(
  parameter int W     = 256,
  parameter int DEPTH = 1
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         i_valid,
  input  logic [W-1:0] i_data,
  output logic         o_valid,
  output logic [W-1:0] o_data,
  output logic         o_busy
);

  logic [DEPTH-1:0] r_valid;
  logic [W-1:0]     r_data [DEPTH];

  // Shift every stage forward one slot per cycle; no backpressure.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_valid <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        r_data[i] <= '0;
      end
    end else begin
      r_valid[0] <= i_valid;
      r_data[0]  <= i_valid ? i_data : '0;
      for (int i = 1; i < DEPTH; i++) begin
        r_valid[i] <= r_valid[i-1];
        r_data[i]  <= r_valid[i-1] ? r_data[i-1] : '0;
      end
    end
  end

  assign o_valid = r_valid[DEPTH-1];
  assign o_data  = r_data[DEPTH-1];
  assign o_busy  = |r_valid;

endmodule

// File: rtl/xor_ref_model.sv
// Golden XOR encryptor: ciphertext = plaintext ^ key, with the key rotating
// left after every accepted block. Output is delayed by LATENCY cycles so it
// lines up cycle-for-cycle with the DUT pipeline.
//
// Handshake: a block transfers on a rising edge where in_valid && in_ready.
// in_ready is combinational, low until a key has been loaded and low during
// any key_load cycle, so a key load and a block accept never share an edge.
// There is no output backpressure; out_valid pulses once per block.
module xor_ref_model
  import xor_pkg::rot_mod;
#(
  parameter int DW      = 256,
  parameter int LATENCY = 2,
  parameter int ROT     = 1,
  parameter int CNT_W   = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             key_load,
  input  logic [DW-1:0]    key_in,
  input  logic             in_valid,
  input  logic [DW-1:0]    in_data,
  output logic             in_ready,
  output logic             out_valid,
  output logic [DW-1:0]    out_code,
  output logic [CNT_W-1:0] blk_cnt,
  output logic             busy
);

  localparam int ROT_M = rot_mod(ROT, DW);

  logic [DW-1:0]    r_key_q;
  logic             r_key_loaded;
  logic             r_s0_valid;
  logic [DW-1:0]    r_s0_data;
  logic [CNT_W-1:0] r_blk_cnt;

  logic             w_accept;
  logic [DW-1:0]    w_key_rot;

  assign in_ready = r_key_loaded && !key_load;
  assign w_accept = in_valid && in_ready;

  // Key for the next block; ROT_M == 0 leaves the key static.
  always_comb begin
    w_key_rot = r_key_q;
    if (ROT_M != 0) begin
      w_key_rot = (r_key_q << ROT_M) | (r_key_q >> (DW - ROT_M));
    end
  end

  // Key register: a load replaces the key, an accept advances it.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_key_q      <= '0;
      r_key_loaded <= 1'b0;
    end else if (key_load) begin
      r_key_q      <= key_in;
      r_key_loaded <= 1'b1;
    end else if (w_accept) begin
      r_key_q      <= w_key_rot;
    end
  end

  // Stage 0 encrypts with the key in force at the accept edge.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_s0_valid <= 1'b0;
      r_s0_data  <= '0;
    end else begin
      r_s0_valid <= w_accept;
      r_s0_data  <= w_accept ? (in_data ^ r_key_q) : '0;
    end
  end

  generate
    if (LATENCY <= 1) begin : g_no_delay
      assign out_valid = r_s0_valid;
      assign out_code  = r_s0_data;
      assign busy      = r_s0_valid;
    end else begin : g_delay
      logic w_dl_busy;

      xor_delay_line #(
        .W     (DW),
        .DEPTH (LATENCY - 1)
      ) u_delay (
        .clk     (clk),
        .rst     (rst),
        .i_valid (r_s0_valid),
        .i_data  (r_s0_data),
        .o_valid (out_valid),
        .o_data  (out_code),
        .o_busy  (w_dl_busy)
      );

      assign busy = r_s0_valid | w_dl_busy;
    end
  endgenerate

  // Count emitted blocks; wraps naturally at 2^CNT_W.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_blk_cnt <= '0;
    end else if (out_valid) begin
      r_blk_cnt <= r_blk_cnt + CNT_W'(1);
    end
  end

  assign blk_cnt = r_blk_cnt;

endmodule

// File: tb/tb_xor_ref_model.sv
// Bench for xor_ref_model: an independent key/latency model pushes expected
// ciphertext into a queue at each accept, a negedge monitor pops and compares
// on every output, and scenario tasks check the specific behaviours.
module tb_xor_ref_model;

  localparam int DW    = 256;
  localparam int LAT   = 2;
  localparam int ROT   = 1;
  localparam int CNT_W = 4;

  logic             clk;
  logic             rst;
  logic             key_load;
  logic [DW-1:0]    key_in;
  logic             in_valid;
  logic [DW-1:0]    in_data;
  logic             in_ready;
  logic             out_valid;
  logic [DW-1:0]    out_code;
  logic [CNT_W-1:0] blk_cnt;
  logic             busy;

  int checks = 0;
  int errors = 0;

  // Scoreboard state
  logic [DW-1:0]    exp_q[$];
  int               due_q[$];
  logic [DW-1:0]    got_q[$];
  xor_pkg::code_t   m_key;
  logic             m_loaded;
  logic [CNT_W-1:0] exp_cnt;
  int               cyc;
  logic             mon_en;

  xor_ref_model #(
    .DW      (DW),
    .LATENCY (LAT),
    .ROT     (ROT),
    .CNT_W   (CNT_W)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .key_load  (key_load),
    .key_in    (key_in),
    .in_valid  (in_valid),
    .in_data   (in_data),
    .in_ready  (in_ready),
    .out_valid (out_valid),
    .out_code  (out_code),
    .blk_cnt   (blk_cnt),
    .busy      (busy)
  );

  // Clock and watchdog
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Reference model: tracks key and pushes expected results at accept edges.
  initial begin
    cyc      = 0;
    m_key    = '0;
    m_loaded = 1'b0;
    exp_cnt  = '0;
  end

  always @(posedge clk) begin
    cyc = cyc + 1;
    if (rst) begin
      m_key    = '0;
      m_loaded = 1'b0;
      exp_cnt  = '0;
      exp_q.delete();
      due_q.delete();
    end else if (key_load) begin
      m_key    = key_in;
      m_loaded = 1'b1;
    end else if (m_loaded && in_valid) begin
      exp_q.push_back(in_data ^ m_key);
      due_q.push_back(cyc + LAT - 1);
      m_key = xor_pkg::rotl(m_key, ROT);
    end
  end

  // Monitor: compares every cycle away from the active edge.
  always @(negedge clk) begin
    logic [DW-1:0] e;
    int            d;
    if (mon_en) begin
      checks++;
      if (in_ready !== (m_loaded && !key_load)) begin
        errors++;
        $display("FAIL mon_in_ready cyc=%0d got=%b exp=%b", cyc, in_ready, m_loaded && !key_load);
      end
      checks++;
      if (busy !== (exp_q.size() != 0)) begin
        errors++;
        $display("FAIL mon_busy cyc=%0d got=%b exp=%b", cyc, busy, exp_q.size() != 0);
      end
      checks++;
      if (blk_cnt !== exp_cnt) begin
        errors++;
        $display("FAIL mon_blk_cnt cyc=%0d got=%0d exp=%0d", cyc, blk_cnt, exp_cnt);
      end
      if (out_valid === 1'b1) begin
        got_q.push_back(out_code);
        exp_cnt = exp_cnt + CNT_W'(1);
        checks++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL mon_unexpected cyc=%0d got=%0h exp=no output", cyc, out_code);
        end else begin
          e = exp_q.pop_front();
          d = due_q.pop_front();
          if (out_code !== e) begin
            errors++;
            $display("FAIL mon_code cyc=%0d got=%0h exp=%0h", cyc, out_code, e);
          end
          checks++;
          if (d != cyc) begin
            errors++;
            $display("FAIL mon_latency got_cyc=%0d exp_cyc=%0d", cyc, d);
          end
        end
      end else begin
        checks++;
        if (out_code !== '0) begin
          errors++;
          $display("FAIL mon_bubble_zero cyc=%0d got=%0h exp=0", cyc, out_code);
        end
        if (due_q.size() != 0 && due_q[0] <= cyc) begin
          checks++;
          errors++;
          $display("FAIL mon_missing cyc=%0d got=no output exp=%0h", cyc, exp_q[0]);
          void'(exp_q.pop_front());
          void'(due_q.pop_front());
        end
      end
    end
  end

  // Driver helpers
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [DW-1:0] rand_word();
    logic [DW-1:0] r;
    for (int i = 0; i < DW / 32; i++) begin
      r[i*32 +: 32] = $urandom;
    end
    return r;
  endfunction

  task automatic test_reset();
    rst = 1'b1;
    tick();
    tick();
    @(negedge clk);
    checks++;
    if (out_valid !== 1'b0 || out_code !== '0 || busy !== 1'b0 ||
        in_ready !== 1'b0 || blk_cnt !== '0) begin
      errors++;
      $display("FAIL reset_state got v=%b code=%0h busy=%b rdy=%b cnt=%0d exp all 0",
               out_valid, out_code, busy, in_ready, blk_cnt);
    end
    @(posedge clk);
    #1;
    rst = 1'b0;
    mon_en = 1'b1;
  endtask

  task automatic test_no_key();
    in_valid = 1'b1;
    in_data  = DW'(3);
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      checks++;
      if (in_ready !== 1'b0 || out_valid !== 1'b0 || out_code !== '0) begin
        errors++;
        $display("FAIL no_key cycle=%0d got rdy=%b v=%b code=%0h exp 0/0/0",
                 i, in_ready, out_valid, out_code);
      end
      tick();
    end
    in_valid = 1'b0;
  endtask

  task automatic test_single();
    key_load = 1'b1;
    key_in   = DW'(1);
    tick();
    key_load = 1'b0;
    in_valid = 1'b1;
    in_data  = DW'(3);
    tick();
    in_valid = 1'b0;
    @(negedge clk);
    checks++;
    if (out_valid !== 1'b0) begin
      errors++;
      $display("FAIL single_early got v=%b exp 0", out_valid);
    end
    tick();
    @(negedge clk);
    checks++;
    if (out_valid !== 1'b1 || out_code !== DW'(2)) begin
      errors++;
      $display("FAIL single_out got v=%b code=%0h exp v=1 code=2", out_valid, out_code);
    end
    tick();
    @(negedge clk);
    checks++;
    if (blk_cnt !== CNT_W'(1)) begin
      errors++;
      $display("FAIL single_cnt got=%0d exp=1", blk_cnt);
    end
    tick();
  endtask

  task automatic test_back_to_back();
    logic [DW-1:0] exp_seq [4];
    exp_seq[0] = DW'(2);
    exp_seq[1] = DW'(1);
    exp_seq[2] = DW'(7);
    exp_seq[3] = DW'(11);
    got_q.delete();
    key_load = 1'b1;
    key_in   = DW'(1);
    tick();
    key_load = 1'b0;
    for (int i = 0; i < 4; i++) begin
      in_valid = 1'b1;
      in_data  = DW'(3);
      @(negedge clk);
      checks++;
      if (in_ready !== 1'b1) begin
        errors++;
        $display("FAIL b2b_ready beat=%0d got=%b exp=1", i, in_ready);
      end
      tick();
    end
    in_valid = 1'b0;
    repeat (5) tick();
    checks++;
    if (got_q.size() != 4) begin
      errors++;
      $display("FAIL b2b_count got=%0d exp=4", got_q.size());
    end else begin
      for (int i = 0; i < 4; i++) begin
        checks++;
        if (got_q[i] !== exp_seq[i]) begin
          errors++;
          $display("FAIL b2b_code idx=%0d got=%0h exp=%0h", i, got_q[i], exp_seq[i]);
        end
      end
    end
  endtask

  task automatic test_load_collide();
    got_q.delete();
    key_load = 1'b1;
    key_in   = DW'(5);
    in_valid = 1'b1;
    in_data  = DW'(9);
    @(negedge clk);
    checks++;
    if (in_ready !== 1'b0) begin
      errors++;
      $display("FAIL collide_ready got=%b exp=0", in_ready);
    end
    tick();
    key_load = 1'b0;
    tick();
    in_valid = 1'b0;
    repeat (4) tick();
    checks++;
    if (got_q.size() != 1 || got_q[0] !== DW'(12)) begin
      errors++;
      $display("FAIL collide_code got_n=%0d got=%0h exp_n=1 exp=c",
               got_q.size(), (got_q.size() != 0) ? got_q[0] : '0);
    end
  endtask

  task automatic test_reset_inflight();
    in_valid = 1'b1;
    in_data  = rand_word();
    tick();
    in_data  = rand_word();
    tick();
    in_valid = 1'b0;
    rst      = 1'b1;
    tick();
    rst      = 1'b0;
    got_q.delete();
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      checks++;
      if (out_valid !== 1'b0 || busy !== 1'b0 || blk_cnt !== '0) begin
        errors++;
        $display("FAIL rst_inflight cycle=%0d got v=%b busy=%b cnt=%0d exp 0/0/0",
                 i, out_valid, busy, blk_cnt);
      end
      tick();
    end
    checks++;
    if (got_q.size() != 0) begin
      errors++;
      $display("FAIL rst_stale got=%0d outputs exp=0", got_q.size());
    end
  endtask

  task automatic test_wrap();
    key_load = 1'b1;
    key_in   = rand_word();
    tick();
    key_load = 1'b0;
    for (int i = 0; i < 17; i++) begin
      in_valid = 1'b1;
      in_data  = rand_word();
      tick();
    end
    in_valid = 1'b0;
    repeat (6) tick();
    @(negedge clk);
    checks++;
    if (blk_cnt !== CNT_W'(1)) begin
      errors++;
      $display("FAIL wrap_cnt got=%0d exp=1", blk_cnt);
    end
    tick();
  endtask

  // Random traffic with gaps and occasional key reloads.
  task automatic test_random();
    for (int i = 0; i < 200; i++) begin
      key_load = ($urandom_range(0, 15) == 0);
      key_in   = rand_word();
      in_valid = ($urandom_range(0, 3) != 0);
      in_data  = rand_word();
      tick();
    end
    key_load = 1'b0;
    in_valid = 1'b0;
    repeat (LAT + 3) tick();
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL random_drain got=%0d pending exp=0", exp_q.size());
    end
  endtask

  initial begin
    mon_en   = 1'b0;
    rst      = 1'b1;
    key_load = 1'b0;
    key_in   = '0;
    in_valid = 1'b0;
    in_data  = '0;
    test_reset();
    test_no_key();
    test_single();
    test_back_to_back();
    test_load_collide();
    test_reset_inflight();
    test_wrap();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
